// File: rtl/uart_pkt_pkg.sv
// uart_pkt_pkg: shared state encoding, error codes and default framing byte for the packet receiver
package uart_pkt_pkg;
    typedef enum logic [2:0] {ST_HUNT, ST_LEN, ST_PAYLOAD, ST_CSUM, ST_READY} pkt_state_e;
    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;
    localparam logic [7:0] SOF_DEFAULT = 8'hA5;
endpackage

// File: rtl/uart_pkt_buf.sv
// uart_pkt_buf: payload storage, synchronous write and asynchronous read, storage not reset
module uart_pkt_buf #(
    parameter int DBIT = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [DBIT-1:0] wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [DBIT-1:0] rdata_o
);
    logic [DBIT-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl: frames UART bytes as SOF/LEN/PAYLOAD/CSUM, checks length, XOR checksum and
// inter-byte gaps, and holds one checked payload for a consumer.
module uart_rx_pkt_ctrl
    import uart_pkt_pkg::*;
#(
    parameter int DBIT = 8,
    parameter int MAX_LEN = 16,
    parameter logic [DBIT-1:0] SOF = SOF_DEFAULT,
    parameter int TIMEOUT_TICKS = 640,
    localparam int AW = $clog2(MAX_LEN),
    localparam int LW = $clog2(MAX_LEN) + 1,
    localparam int GW = $clog2(TIMEOUT_TICKS + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rxdone,
    input  logic [DBIT-1:0] rxdout,
    input  logic            stick,
    input  logic            rd_en,
    output logic [DBIT-1:0] rd_data,
    output logic            pkt_valid,
    output logic [LW-1:0]   pkt_len,
    output logic            pkt_err,
    output logic [1:0]      err_code,
    output logic            overrun
);
    pkt_state_e      state_q;
    logic [LW-1:0]   len_q, pkt_len_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [DBIT-1:0] csum_q;
    logic [GW-1:0]   gap_q;
    logic            pkt_valid_q, pkt_err_q, overrun_q;
    logic [1:0]      err_code_q;
    logic            framing, len_bad, last_wr, last_rd, timeout;

    assign framing = state_q inside {ST_LEN, ST_PAYLOAD, ST_CSUM};
    // Length is judged on the full byte so e.g. 8'h90 is rejected rather than aliasing to 16.
    assign len_bad = (rxdout == '0) || (rxdout > DBIT'(MAX_LEN));
    assign last_wr = LW'(wr_ptr_q) == len_q - LW'(1);
    assign last_rd = LW'(rd_ptr_q) == pkt_len_q - LW'(1);
    assign timeout = framing && stick && !rxdone && gap_q == GW'(TIMEOUT_TICKS - 1);

    uart_pkt_buf #(.DBIT(DBIT), .DEPTH(MAX_LEN)) u_buf (
        .clk_i   (clk),
        .we_i    (state_q == ST_PAYLOAD && rxdone),
        .waddr_i (wr_ptr_q),
        .wdata_i (rxdout),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            len_q       <= '0;
            pkt_len_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            csum_q      <= '0;
            gap_q       <= '0;
            pkt_valid_q <= 1'b0;
            pkt_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
            err_code_q  <= '0;
        end else begin
            pkt_err_q <= 1'b0;
            overrun_q <= 1'b0;
            gap_q     <= (!framing || rxdone) ? '0 : stick ? gap_q + GW'(1) : gap_q;
            if (timeout) begin
                state_q    <= ST_HUNT;
                pkt_err_q  <= 1'b1;
                err_code_q <= ERR_TMO;
            end else begin
                case (state_q)
                    ST_HUNT: if (rxdone && rxdout == SOF) state_q <= ST_LEN;
                    ST_LEN: if (rxdone) begin
                        if (len_bad) begin
                            state_q    <= ST_HUNT;
                            pkt_err_q  <= 1'b1;
                            err_code_q <= ERR_LEN;
                        end else begin
                            state_q  <= ST_PAYLOAD;
                            len_q    <= LW'(rxdout);
                            csum_q   <= rxdout;
                            wr_ptr_q <= '0;
                        end
                    end
                    ST_PAYLOAD: if (rxdone) begin
                        csum_q   <= csum_q ^ rxdout;
                        wr_ptr_q <= wr_ptr_q + AW'(1);
                        if (last_wr) state_q <= ST_CSUM;
                    end
                    ST_CSUM: if (rxdone) begin
                        if (rxdout == csum_q) begin
                            state_q     <= ST_READY;
                            pkt_valid_q <= 1'b1;
                            pkt_len_q   <= len_q;
                            rd_ptr_q    <= '0;
                        end else begin
                            state_q    <= ST_HUNT;
                            pkt_err_q  <= 1'b1;
                            err_code_q <= ERR_CSUM;
                        end
                    end
                    ST_READY: begin
                        overrun_q <= rxdone;
                        if (rd_en && last_rd) begin
                            state_q     <= ST_HUNT;
                            pkt_valid_q <= 1'b0;
                        end else if (rd_en) begin
                            rd_ptr_q <= rd_ptr_q + AW'(1);
                        end
                    end
                    default: state_q <= ST_HUNT;
                endcase
            end
        end
    end

    assign pkt_valid = pkt_valid_q;
    assign pkt_len   = pkt_len_q;
    assign pkt_err   = pkt_err_q;
    assign err_code  = err_code_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// tb_uart_rx_pkt_ctrl: directed and randomized frames checked against a frame-level model of the
// expected outcome (XOR of length and payload, length bounds, tick budget).
module tb_uart_rx_pkt_ctrl;
    logic       clk = 1'b0, reset = 1'b1, rxdone = 1'b0, stick = 1'b0, rd_en = 1'b0;
    logic [7:0] rxdout = '0, rd_data;
    logic       pkt_valid, pkt_err, overrun;
    logic [4:0] pkt_len;
    logic [1:0] err_code;
    int         n_pass = 0, n_chk = 0, n_fail = 0, n_err = 0, n_ovr = 0;
    logic [7:0] pay [$];

    uart_rx_pkt_ctrl dut (
        .clk(clk), .reset(reset), .rxdone(rxdone), .rxdout(rxdout), .stick(stick), .rd_en(rd_en),
        .rd_data(rd_data), .pkt_valid(pkt_valid), .pkt_len(pkt_len), .pkt_err(pkt_err),
        .err_code(err_code), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pkt_err) n_err++;
        if (overrun) n_ovr++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rxdone = 1'b1;
        rxdout = b;
        step();
        rxdone = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            stick = 1'b1;
            step();
            stick = 1'b0;
            step();
        end
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] len, input logic [7:0] p [$]);
        logic [7:0] s;
        s = len;
        foreach (p[i]) s ^= p[i];
        return s;
    endfunction

    task automatic rand_pay(input int l);
        pay.delete();
        repeat (l) pay.push_back(8'($urandom));
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] cs);
        send(8'hA5);
        send(len);
        foreach (pay[i]) send(pay[i]);
        send(cs);
    endtask

    task automatic read_pkt();
        foreach (pay[i]) begin
            chk("rd_data", rd_data, pay[i]);
            rd_en = 1'b1;
            step();
            rd_en = 1'b0;
        end
        chk("valid_drop", pkt_valid, 0);
    endtask

    task automatic good_frame(input int l);
        rand_pay(l);
        send_frame(8'(l), xsum(8'(l), pay));
        chk("good_valid", pkt_valid, 1);
        chk("good_len", pkt_len, l);
        read_pkt();
    endtask

    initial begin
        int e0, o0, l;
        logic [7:0] b, cs;
        logic [7:0] bad_lens [3];
        bit good;
        repeat (3) step();
        chk("rst_valid", pkt_valid, 0);
        chk("rst_len", pkt_len, 0);
        chk("rst_err", pkt_err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_ovr", overrun, 0);
        reset = 1'b0;
        step();

        // Example frame from the plan: checksum 03 over length and payload
        pay = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h03, 8'h03);
        chk("ex_valid", pkt_valid, 1);
        chk("ex_len", pkt_len, 3);
        read_pkt();

        pay = '{8'hAA, 8'hBB};
        e0 = n_err;
        send_frame(8'h02, 8'hFF);
        chk("csum_err", pkt_err, 1);
        chk("csum_code", err_code, 2);
        chk("csum_valid", pkt_valid, 0);
        step();
        chk("csum_pulse", pkt_err, 0);
        chk("csum_count", n_err - e0, 1);
        good_frame(5);
        chk("code_hold", err_code, 2);

        bad_lens = '{8'h00, 8'h11, 8'h90};
        foreach (bad_lens[i]) begin
            e0 = n_err;
            send(8'hA5);
            send(bad_lens[i]);
            chk("len_err", pkt_err, 1);
            chk("len_code", err_code, 1);
            step();
            chk("len_pulse", n_err - e0, 1);
        end
        e0 = n_err;
        o0 = n_ovr;
        send(8'h00);
        send(8'hFF);
        step();
        chk("noise_quiet", (n_err - e0) + (n_ovr - o0), 0);
        good_frame(16);
        good_frame(1);

        pay = '{8'h01};
        e0 = n_err;
        send(8'hA5);
        send(8'h04);
        send(8'h01);
        ticks(639);
        chk("tmo_early", n_err - e0, 0);
        stick = 1'b1;
        step();
        stick = 1'b0;
        chk("tmo_err", pkt_err, 1);
        chk("tmo_code", err_code, 3);
        step();
        chk("tmo_pulse", n_err - e0, 1);

        pay = '{8'h01, 8'h02, 8'h03, 8'h04};
        e0 = n_err;
        send(8'hA5);
        send(8'h04);
        send(8'h01);
        ticks(639);
        stick = 1'b1;
        rxdone = 1'b1;
        rxdout = 8'h02;
        step();
        stick = 1'b0;
        rxdone = 1'b0;
        ticks(639);
        send(8'h03);
        send(8'h04);
        send(xsum(8'h04, pay));
        chk("tick_win_err", n_err - e0, 0);
        chk("tick_win_valid", pkt_valid, 1);
        read_pkt();

        rand_pay(5);
        send_frame(8'd5, xsum(8'd5, pay));
        o0 = n_ovr;
        send(8'hA5);
        chk("ovr_1", overrun, 1);
        send(8'h3C);
        chk("ovr_2", overrun, 1);
        step();
        chk("ovr_end", overrun, 0);
        chk("ovr_count", n_ovr - o0, 2);
        chk("ovr_valid", pkt_valid, 1);
        chk("ovr_len", pkt_len, 5);
        read_pkt();
        pay = '{8'h7E};
        send_frame(8'h01, 8'h7F);
        chk("b2b_valid", pkt_valid, 1);
        read_pkt();

        e0 = n_err;
        send(8'hA5);
        send(8'h05);
        send(8'h12);
        send(8'h34);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_valid", pkt_valid, 0);
        chk("mid_rst_len", pkt_len, 0);
        chk("mid_rst_code", err_code, 0);
        step();
        chk("mid_rst_noerr", n_err - e0, 0);
        good_frame(7);

        repeat (24) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                send(b == 8'hA5 ? 8'h00 : b);
            end
            l = $urandom_range(1, 16);
            rand_pay(l);
            good = $urandom_range(0, 3) != 0;
            cs = xsum(8'(l), pay) ^ (good ? 8'h00 : 8'($urandom_range(1, 255)));
            send_frame(8'(l), cs);
            if (good) begin
                chk("rnd_valid", pkt_valid, 1);
                chk("rnd_len", pkt_len, l);
                read_pkt();
            end else begin
                chk("rnd_err", pkt_err, 1);
                chk("rnd_code", err_code, 2);
                chk("rnd_novalid", pkt_valid, 0);
            end
            repeat ($urandom_range(1, 3)) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
